// File: rtl/csa_stream_accumulator.sv
// Streaming packet accumulator: each accepted operand is folded into a redundant
// (sum, carry) pair by one 3:2 compression; the pair is resolved bit-serially at packet end.
module csa_stream_accumulator #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int               CNT_W    = (ACC_W > 1) ? $clog2(ACC_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(ACC_W - 1);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ACC_W-1:0] s_acc;
    logic [ACC_W-1:0] c_acc;
    logic [ACC_W-1:0] r_acc;
    logic             ovf_sticky;
    logic             cy;
    logic [CNT_W-1:0] bit_cnt;

    logic             accept;
    logic             resolve_step;
    logic             resolve_done;
    logic             drain;

    logic [ACC_W-1:0] d_ext;
    logic [ACC_W-1:0] maj_vec;
    logic [ACC_W-1:0] s_fold;
    logic [ACC_W-1:0] c_fold;
    logic [ACC_W-1:0] r_next;
    logic             r_bit;
    logic             cy_next;

    // 3:2 compression of the stored pair with the incoming operand; the carry word
    // shifts up one place, and its top bit leaves the word as a multiple of 2^ACC_W.
    always_comb begin
        d_ext   = ACC_W'(in_data);
        maj_vec = (s_acc & c_acc) | (s_acc & d_ext) | (c_acc & d_ext);
        s_fold  = s_acc ^ c_acc ^ d_ext;
        c_fold  = maj_vec << 1;
    end

    // One full-adder slice of the carry-propagate pass, selected by the bit counter.
    always_comb begin
        r_bit           = s_acc[bit_cnt] ^ c_acc[bit_cnt] ^ cy;
        cy_next         = (s_acc[bit_cnt] & c_acc[bit_cnt]) |
                          (s_acc[bit_cnt] & cy) |
                          (c_acc[bit_cnt] & cy);
        r_next          = r_acc;
        r_next[bit_cnt] = r_bit;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        accept       = 1'b0;
        resolve_step = 1'b0;
        resolve_done = 1'b0;
        drain        = 1'b0;
        unique case (state)
            ACCUM: begin
                in_ready = !rst;
                accept   = in_valid;
                if (in_valid && in_last) begin
                    state_next = RESOLVE;
                end
            end
            RESOLVE: begin
                resolve_step = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    resolve_done = 1'b1;
                    state_next   = OUTPUT;
                end
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    drain      = 1'b1;
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_acc      <= '0;
            c_acc      <= '0;
            r_acc      <= '0;
            ovf_sticky <= 1'b0;
            cy         <= 1'b0;
            bit_cnt    <= '0;
            out_sum    <= '0;
            out_ovf    <= 1'b0;
        end else begin
            if (accept) begin
                s_acc <= s_fold;
                c_acc <= c_fold;
                if (maj_vec[ACC_W-1]) begin
                    ovf_sticky <= 1'b1;
                end
                if (in_last) begin
                    bit_cnt <= '0;
                    cy      <= 1'b0;
                end
            end

            if (resolve_step) begin
                r_acc   <= r_next;
                cy      <= cy_next;
                bit_cnt <= resolve_done ? '0 : bit_cnt + CNT_W'(1);
                if (resolve_done) begin
                    out_sum <= r_next;
                    out_ovf <= ovf_sticky | cy_next;
                end
            end

            // out_sum/out_ovf deliberately survive the handshake; out_valid qualifies them.
            if (drain) begin
                s_acc      <= '0;
                c_acc      <= '0;
                ovf_sticky <= 1'b0;
                cy         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed and random stimulus for csa_stream_accumulator; results are checked against a
// golden-sum scoreboard filled at packet end and drained at each output handshake.
module tb_csa_stream_accumulator;

    localparam int DATA_W = 4;
    localparam int ACC_W  = 8;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic             ovf;
    } result_t;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              in_valid  = 1'b0;
    logic              in_last   = 1'b0;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] in_data   = '0;
    logic              in_ready;
    logic              out_valid;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    int          compared   = 0;
    int          mismatched = 0;
    int unsigned edge_cnt   = 0;
    int          golden     = 0;
    bit          rand_mode  = 1'b0;
    result_t     sb[$];
    result_t     mon_exp;

    csa_stream_accumulator #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        compared++;
        mismatched++;
        $error("FAIL %s: observed no DUT response expected one within budget", tag);
    endtask

    // Advance to just after the next rising edge; in random mode also re-roll out_ready.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_op(input logic [DATA_W-1:0] d, input logic last);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int n = 0; n < 500 && !done; n++) begin
            @(negedge clk);
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) begin
            timeout_fail("accept_timeout");
        end else begin
            golden += int'(d);
            if (last) begin
                sb.push_back(result_t'{ACC_W'(golden), (golden >= (1 << ACC_W))});
                golden = 0;
            end
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            ok = out_valid;
        end
        if (!ok) timeout_fail("valid_timeout");
    endtask

    task automatic finish_packet();
        bit ok;
        wait_valid(60, ok);
        tick();
    endtask

    // Output-side scoreboard: every handshake pops one expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $error("FAIL unexpected_result: observed sum %0d with nothing pending expected no output", out_sum);
            end else begin
                mon_exp = sb.pop_front();
                check("result_sum", 32'(out_sum), 32'(mon_exp.sum));
                check("result_ovf", 32'(out_ovf), 32'(mon_exp.ovf));
            end
        end
    end

    initial begin
        bit          ok;
        int unsigned acc_edge;
        int unsigned hs_edge;
        int          len;

        // Reset state while rst is held from time zero.
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sum", 32'(out_sum), 0);
        check("rst_out_ovf", 32'(out_ovf), 0);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);
        tick();

        // Basic back-to-back packet and result latency.
        send_op(4'd5, 1'b0);
        send_op(4'd9, 1'b0);
        send_op(4'd15, 1'b1);
        acc_edge = edge_cnt;
        wait_valid(20, ok);
        check("latency_edges", edge_cnt - acc_edge, 8);
        tick();
        @(negedge clk);
        check("post_hs_out_valid", 32'(out_valid), 0);
        check("post_hs_sum_held", 32'(out_sum), 29);
        tick();

        // Reset in the middle of RESOLVE discards everything.
        send_op(4'd9, 1'b1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        sb.delete();
        golden = 0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_out_sum", 32'(out_sum), 0);
        check("midrst_out_ovf", 32'(out_ovf), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_release_ready", 32'(in_ready), 1);
        tick();
        send_op(4'd3, 1'b0);
        send_op(4'd4, 1'b1);
        finish_packet();

        // Overflow boundary: 255, 270, then zero.
        for (int i = 0; i < 17; i++) send_op(4'd15, i == 16);
        finish_packet();
        for (int i = 0; i < 18; i++) send_op(4'd15, i == 17);
        finish_packet();
        send_op(4'd0, 1'b1);
        finish_packet();

        // Backpressure with in_valid pulsing while the result is held.
        out_ready = 1'b0;
        send_op(4'd12, 1'b0);
        send_op(4'd13, 1'b1);
        wait_valid(20, ok);
        tick();
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            in_data  = 4'd15;
            in_last  = 1'b1;
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_out_sum", 32'(out_sum), 25);
            check("bp_out_ovf", 32'(out_ovf), 0);
            check("bp_in_ready", 32'(in_ready), 0);
            tick();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 1);
        check("bp_release_out_valid", 32'(out_valid), 0);
        tick();

        // Input stalls inside a packet, then an immediate single-operand packet.
        send_op(4'd1, 1'b0);
        idle(3);
        send_op(4'd2, 1'b0);
        idle(2);
        send_op(4'd6, 1'b1);
        wait_valid(20, ok);
        hs_edge = edge_cnt + 1;
        tick();
        send_op(4'd7, 1'b1);
        check("restart_accept_edge", edge_cnt, hs_edge + 1);
        finish_packet();

        // Random regression with random input gaps and output backpressure.
        rand_mode = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
                send_op(DATA_W'($urandom_range(0, 15)), i == len - 1);
            end
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 200 && sb.size() != 0; n++) tick();
        check("drain_pending", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/csa_stream_accumulator.md
Name: csa_stream_accumulator

Overview:
- Upstream/downstream companion to the 4-bit carry-save adder stage.
- Accepts a packet of DATA_W-bit operands over a valid/ready stream and folds each one into a redundant (sum, carry) accumulator with one 3:2 carry-save compression per accepted operand.
- After the packet's last operand, resolves the redundant pair to binary with a bit-serial carry-propagate pass.
- Presents the binary result and an overflow flag on an output valid/ready handshake.

Parameters:
- DATA_W, 4, operand width; operands zero-extended to ACC_W.
- ACC_W, 8, accumulator/result width; must be greater than or equal to DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand.
- in_data  input  DATA_W  operand, unsigned.
- in_last  input  1  marks final operand of packet; sampled with in_data.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_sum  output  ACC_W  packet sum modulo 2^ACC_W.
- out_ovf  output  1  true packet sum is at least 2^ACC_W.

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-high.
- States: ACCUM, RESOLVE, OUTPUT.
- Reset (async, immediate):
  - state=ACCUM; S=0, C=0, ovf_sticky=0, cy=0, bit counter=0.
  - out_sum=0, out_valid=0, out_ovf=0.
  - in_ready=0 while rst is high.
- ACCUM:
  - in_ready=1.
  - Accept when in_valid&in_ready at a rising edge; D = zero-extended in_data.
  - S' = S^C^D.
  - M = maj(S,C,D); C' = {M[ACC_W-2:0],0}.
  - If M[ACC_W-1]=1, set ovf_sticky (each dropped carry equals exactly 2^ACC_W).
  - Accept with in_last=1 goes to RESOLVE with counter=0 and cy=0.
  - Accept with in_last=0 stays in ACCUM.
  - A one-operand packet is legal.
- RESOLVE:
  - in_ready=0; in_valid is ignored.
  - Each cycle, bit i=counter:
    - r[i] = S[i]^C[i]^cy.
    - cy' = maj(S[i],C[i],cy).
    - counter increments.
  - After bit ACC_W-1, go to OUTPUT:
    - out_sum = r.
    - out_ovf = ovf_sticky | final cy.
    - out_valid=1.
- Latency: out_valid rises exactly ACC_W clock edges after the edge that accepted the last operand.
- OUTPUT:
  - out_sum and out_ovf are registered and held stable while out_valid=1; in_ready=0.
  - On out_valid&out_ready, at the same edge:
    - out_valid goes to 0.
    - S, C, ovf_sticky and cy are cleared.
    - state goes to ACCUM.
  - The earliest next operand is accepted one cycle after the output handshake; no overlap of packets.
- out_sum keeps the last result after the handshake until the next result loads; only out_valid qualifies it.
- Input stalls: in_valid gaps inside a packet are allowed; S and C hold.
- Reset mid-operation (any state) discards the partial packet and result; the next packet starts from zero with no residue.
- Arithmetic invariant: in ACCUM, (S + C) mod 2^ACC_W equals the running sum mod 2^ACC_W.
- Width: counter is clog2(ACC_W) bits; the design is valid for any ACC_W≥DATA_W≥1.

Test Plan:
1. Reset: hold rst high mid-RESOLVE, then release. Required: out_valid=0, out_sum=0, out_ovf=0; in_ready=1 one cycle after release. Then send 3, 4(last). Required: out_sum=7, out_ovf=0, no residue.
2. Basic packet (DATA_W=4, ACC_W=8): send 5, 9, 15(last) back-to-back. Required: out_sum=29, out_ovf=0, out_valid exactly 8 edges after the last accept.
3. Overflow boundary:
   - 17×15 (=255) gives out_sum=255, out_ovf=0.
   - 18×15 (=270) gives out_sum=14, out_ovf=1.
   - 0 (last) gives out_sum=0, out_ovf=0.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid while pulsing in_valid. Required: out_sum/out_ovf stable, in_ready=0, no operand absorbed. Then out_ready=1: handshake; in_ready=1 on the next cycle.
5. Stalls and single operand:
   - Packet 1, gap of 3 idle cycles, 2, gap, 6(last) gives 9.
   - Immediate next packet 7(last) gives 7, with the first operand accepted exactly one cycle after the previous output handshake.
6. Random regression: 1000 packets of random length 1–40 with random in_valid/out_ready. Required: out_sum == golden sum mod 256 and out_ovf == (golden sum ≥ 256) for every packet.
